accel_bus_responder: RTL

- Accelerator-side responder for the CPU accelerator bus. Decodes bus_rdwr/bus_accregaddr/bus_data into an 8 x 16-bit register bank and returns read data on the shared tristate bus in the same cycle.
- Runs the start/done handshake with the compute engine and presents parameter registers to it.
- Measures engine run time and enforces a watchdog timeout.

---
 rtl/accel_bus_responder_if.sv | 25 ++
 rtl/accel_bus_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/accel_bus_responder_if.sv
// CPU accelerator bus control signals shared between the CPU (master) and
// the accelerator responder (slave). The tristate data bus stays a module port.
interface accel_bus_responder_if;
  logic       bus_accel_en;
  logic       bus_accel_start;
  logic [1:0] bus_rdwr;
  logic [2:0] bus_accregaddr;
  logic       bus_accel_done;

  modport master (
    output bus_accel_en,
    output bus_accel_start,
    output bus_rdwr,
    output bus_accregaddr,
    input  bus_accel_done
  );

  modport slave (
    input  bus_accel_en,
    input  bus_accel_start,
    input  bus_rdwr,
    input  bus_accregaddr,
    output bus_accel_done
  );
endinterface

// File: rtl/accel_bus_responder.sv
// Accelerator-side bus responder: 8 x 16-bit register bank on a shared tristate
// bus, start/done handshake with the compute engine, run-time counter and watchdog.
module accel_bus_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [15:0] SCRATCH_RST    = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  accel_bus_responder_if.slave        bus,
  inout  wire  [15:0]                 bus_data,
  output logic                        eng_start,
  output logic [15:0]                 eng_src_addr,
  output logic [15:0]                 eng_dst_addr,
  output logic [15:0]                 eng_len,
  output logic [15:0]                 eng_cfg,
  input  logic                        eng_done,
  input  logic [15:0]                 eng_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        WDOG_ON      = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cfg_q, cfg_d;
  logic [15:0] result_q, result_d;
  logic [15:0] cycles_q, cycles_d;
  logic [15:0] scratch_q, scratch_d;
  logic        err_q, err_d;
  logic        eng_start_q, eng_start_d;

  logic        busy;
  logic        done;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] rd_data;

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign wr_en = (bus.bus_rdwr == 2'b01);
  assign rd_en = (bus.bus_rdwr == 2'b10);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cfg_d       = cfg_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    scratch_d   = scratch_q;
    err_d       = err_q;
    eng_start_d = 1'b0;

    // Bus writes are applied first so a same-edge timeout can still set err.
    if (wr_en) begin
      case (bus.bus_accregaddr)
        3'd0: if (bus_data[15]) err_d = 1'b0;
        3'd1: if (!busy) src_d = bus_data;
        3'd2: if (!busy) dst_d = bus_data;
        3'd3: if (!busy) len_d = bus_data;
        3'd4: if (!busy) cfg_d = bus_data;
        3'd7: scratch_d = bus_data;
        default: ;
      endcase
    end

    if (!bus.bus_accel_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.bus_accel_start) begin
            state_d     = RUN;
            eng_start_d = 1'b1;
            cycles_d    = '0;
          end
        end
        RUN: begin
          if (eng_done) begin
            state_d  = DONE;
            result_d = eng_result;
          end else if (WDOG_ON && (cycles_q == TIMEOUT_LAST)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (cycles_q != '1) begin
            cycles_d = cycles_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cfg_q       <= '0;
      result_q    <= '0;
      cycles_q    <= '0;
      scratch_q   <= SCRATCH_RST;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cfg_q       <= cfg_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
      scratch_q   <= scratch_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.bus_accregaddr)
      3'd0: rd_data = {13'b0, err_q, done, busy};
      3'd1: rd_data = src_q;
      3'd2: rd_data = dst_q;
      3'd3: rd_data = len_q;
      3'd4: rd_data = cfg_q;
      3'd5: rd_data = result_q;
      3'd6: rd_data = cycles_q;
      3'd7: rd_data = scratch_q;
      default: rd_data = '0;
    endcase
  end

  assign bus_data           = rd_en ? rd_data : 'z;
  assign bus.bus_accel_done = done;
  assign eng_start          = eng_start_q;
  assign eng_src_addr       = src_q;
  assign eng_dst_addr       = dst_q;
  assign eng_len            = len_q;
  assign eng_cfg            = cfg_q;

endmodule
